// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter fed by a circular transmit FIFO.
// The line is registered one clock behind the FSM so tx never glitches.
module uart_tx #(
    parameter int UART_BAUD  = 115200,
    parameter int F_CLK      = 12_000_000,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tx_dv,
    input  logic [7:0]                  tx_byte,
    output logic                        tx_ready,
    output logic                        tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CPB = F_CLK / UART_BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
    localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          ready_q, ready_d;

    logic accept;
    logic pop;
    logic bit_end;
    logic fifo_nempty;

    // ready is registered, so a pop never frees a slot for the same edge
    assign accept      = tx_dv & ready_q;
    assign fifo_nempty = (count_q != '0);
    assign bit_end     = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) state_d = STOP;
                    else idx_d = idx_q + 3'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (fifo_nempty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) shift_d = mem_q[rd_ptr_q];
        if (state_q == IDLE || bit_end) cnt_d = '0;
        else cnt_d = cnt_q + 1'b1;
        if (state_d != state_q) idx_d = '0;
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[idx_q];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx_busy = (state_q != IDLE);
    assign tx      = tx_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        ready_d = (count_d < DEPTH_V);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= tx_byte;
    end

    assign tx_ready   = ready_q;
    assign fifo_count = count_q;

endmodule
